// File: rtl/abro_job_arbiter.sv
// abro_job_arbiter
// Round-robin scheduler sharing one ABRO engine among N requesters. A granted
// requester gets one job: first input pulse, GAP_CYC idle cycles, second input
// pulse, wait for O (bounded by TIMEOUT), restart pulse, then a done status.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   i_req[N]            job request levels, sampled only while idle
//   i_order[N]          0: A then B, 1: B then A; latched at grant
//   o_grant[N]          one-hot grant, held from first pulse through done
//   o_done_ok/o_done_err one-cycle job status pulses
//   o_busy              high whenever a job is in progress
//   o_job_cnt[8]        completed job count, wrapping
//   o_abro_a/b/r        engine A, B and restart inputs
//   i_abro_o            engine O output
module abro_job_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned GAP_CYC = 2,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] i_req,
    input  logic [N-1:0] i_order,
    output logic [N-1:0] o_grant,
    output logic         o_done_ok,
    output logic         o_done_err,
    output logic         o_busy,
    output logic [7:0]   o_job_cnt,
    output logic         o_abro_a,
    output logic         o_abro_b,
    output logic         o_abro_r,
    input  logic         i_abro_o
);

    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        StIdle, StFirst, StGap, StSecond, StWaitO, StRestart, StDone
    } state_e;

    state_e            r_state, w_state_d;
    logic [7:0]        r_cnt, w_cnt_d;
    logic [IdxW-1:0]   r_win, w_win_d;
    logic [IdxW-1:0]   r_last, w_last_d;
    logic              r_ord, w_ord_d;
    logic              r_ok, w_ok_d;

    logic              w_found;
    logic [IdxW-1:0]   w_pick;
    logic [IdxW-1:0]   w_idx;

    // Round-robin search starting just after the last served requester.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int i = 1; i <= int'(N); i++) begin
            w_idx = IdxW'((int'(r_last) + i) % int'(N));
            if (!w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_win_d   = r_win;
        w_ord_d   = r_ord;
        w_ok_d    = r_ok;
        w_last_d  = r_last;
        unique case (r_state)
            StIdle: begin
                if (w_found) begin
                    w_win_d   = w_pick;
                    w_ord_d   = i_order[w_pick];
                    w_state_d = StFirst;
                end
            end
            StFirst: begin
                w_cnt_d   = '0;
                w_state_d = (GAP_CYC > 0) ? StGap : StSecond;
            end
            StGap: begin
                if (r_cnt == 8'(GAP_CYC - 1)) begin
                    w_state_d = StSecond;
                end else begin
                    w_cnt_d = r_cnt + 8'd1;
                end
            end
            StSecond: begin
                w_cnt_d   = '0;
                w_state_d = StWaitO;
            end
            StWaitO: begin
                // O wins over timeout on the last allowed cycle.
                if (i_abro_o) begin
                    w_ok_d    = 1'b1;
                    w_state_d = StRestart;
                end else if (r_cnt == 8'(TIMEOUT - 1)) begin
                    w_ok_d    = 1'b0;
                    w_state_d = StRestart;
                end else begin
                    w_cnt_d = r_cnt + 8'd1;
                end
            end
            StRestart: w_state_d = StDone;
            StDone: begin
                w_last_d  = r_win;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    logic [N-1:0] w_grant_d;
    logic         w_busy_d;
    logic         w_a_d;
    logic         w_b_d;

    always_comb begin
        w_busy_d  = (w_state_d != StIdle);
        w_grant_d = w_busy_d ? (N'(1) << w_win_d) : '0;
        w_a_d     = ((w_state_d == StFirst) && !w_ord_d) ||
                    ((w_state_d == StSecond) && w_ord_d);
        w_b_d     = ((w_state_d == StFirst) && w_ord_d) ||
                    ((w_state_d == StSecond) && !w_ord_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_win      <= '0;
            r_ord      <= 1'b0;
            r_ok       <= 1'b0;
            r_last     <= IdxW'(N - 1);
            o_grant    <= '0;
            o_done_ok  <= 1'b0;
            o_done_err <= 1'b0;
            o_busy     <= 1'b0;
            o_job_cnt  <= '0;
            o_abro_a   <= 1'b0;
            o_abro_b   <= 1'b0;
            o_abro_r   <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_win      <= w_win_d;
            r_ord      <= w_ord_d;
            r_ok       <= w_ok_d;
            r_last     <= w_last_d;
            o_grant    <= w_grant_d;
            o_done_ok  <= (w_state_d == StDone) && w_ok_d;
            o_done_err <= (w_state_d == StDone) && !w_ok_d;
            o_busy     <= w_busy_d;
            o_job_cnt  <= o_job_cnt + ((w_state_d == StDone) ? 8'd1 : 8'd0);
            o_abro_a   <= w_a_d;
            o_abro_b   <= w_b_d;
            o_abro_r   <= (w_state_d == StRestart);
        end
    end

endmodule

// File: tb/tb_abro_job_arbiter.sv
// Directed bench for abro_job_arbiter: main instance (GAP_CYC=2, TIMEOUT=16)
// plus a GAP_CYC=0 instance, each driven against a small ABRO engine model.
module tb_abro_job_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req, order, grant;
    logic       done_ok, done_err, busy, a, b, r, o;
    logic [7:0] job_cnt;

    logic [3:0] z_req, z_order, z_grant;
    logic       z_done_ok, z_done_err, z_busy, z_a, z_b, z_r, z_o;
    logic [7:0] z_job_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    abro_job_arbiter #(.N(4), .GAP_CYC(2), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .i_req(req), .i_order(order), .o_grant(grant),
        .o_done_ok(done_ok), .o_done_err(done_err), .o_busy(busy), .o_job_cnt(job_cnt),
        .o_abro_a(a), .o_abro_b(b), .o_abro_r(r), .i_abro_o(o)
    );

    abro_job_arbiter #(.N(4), .GAP_CYC(0), .TIMEOUT(16)) dut_gap0 (
        .clk(clk), .reset(reset), .i_req(z_req), .i_order(z_order), .o_grant(z_grant),
        .o_done_ok(z_done_ok), .o_done_err(z_done_err), .o_busy(z_busy),
        .o_job_cnt(z_job_cnt), .o_abro_a(z_a), .o_abro_b(z_b), .o_abro_r(z_r),
        .i_abro_o(z_o)
    );

    // ABRO engine models: O rises the cycle after both A and B have been seen.
    logic e_sa, e_sb, e_o, e_en, o_force;
    logic z_sa, z_sb, z_eo;
    assign o   = (e_o & e_en) | o_force;
    assign z_o = z_eo;

    always @(posedge clk or posedge reset) begin
        if (reset || r) begin
            e_sa <= 1'b0; e_sb <= 1'b0; e_o <= 1'b0;
        end else begin
            e_sa <= e_sa | a;
            e_sb <= e_sb | b;
            e_o  <= (e_sa | a) & (e_sb | b);
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset || z_r) begin
            z_sa <= 1'b0; z_sb <= 1'b0; z_eo <= 1'b0;
        end else begin
            z_sa <= z_sa | z_a;
            z_sb <= z_sb | z_b;
            z_eo <= (z_sa | z_a) & (z_sb | z_b);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_grant(input int lim);
        int n;
        n = 0;
        while (grant == 4'b0000 && n < lim) begin
            step();
            n++;
        end
        chk("grant_wait_bound", 32'(n < lim), 1);
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while (busy && n < lim) begin
            step();
            n++;
        end
        chk("idle_wait_bound", 32'(n < lim), 1);
    endtask

    logic [3:0] rr_exp [5];

    initial begin
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        reset = 1'b1; req = '0; order = '0; e_en = 1'b1; o_force = 1'b0;
        z_req = '0; z_order = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_job_cnt", 32'(job_cnt), 0);
        chk("rst_abr", 32'({a, b, r, done_ok, done_err}), 0);
        reset = 1'b0;
        step();

        // GAP_CYC=0: A, B back to back, 5-cycle job.
        z_req = 4'b0001;
        step();
        chk("g0_c1_grant", 32'(z_grant), 1);
        chk("g0_c1_ab", 32'({z_a, z_b}), 2);
        z_req = '0;
        step();
        chk("g0_c2_ab", 32'({z_a, z_b}), 1);
        step();
        chk("g0_c3_abr", 32'({z_a, z_b, z_r}), 0);
        step();
        chk("g0_c4_r", 32'(z_r), 1);
        step();
        chk("g0_c5_done", 32'({z_done_ok, z_done_err}), 2);
        step();
        chk("g0_c6_idle", 32'({z_busy, z_grant}), 0);
        chk("g0_job_cnt", 32'(z_job_cnt), 1);

        // Single ok job, requester 2, A first.
        req = 4'b0100;
        step();
        chk("t1_c1_grant", 32'(grant), 4);
        chk("t1_c1_ab", 32'({a, b, busy}), 5);
        req = '0;
        step();
        chk("t1_c2_ab", 32'({a, b}), 0);
        step();
        chk("t1_c3_ab", 32'({a, b}), 0);
        step();
        chk("t1_c4_ab", 32'({a, b}), 1);
        step();
        chk("t1_c5_abr", 32'({a, b, r}), 0);
        step();
        chk("t1_c6_abr", 32'({a, b, r}), 1);
        step();
        chk("t1_c7_done", 32'({done_ok, done_err, r}), 4);
        chk("t1_c7_grant", 32'(grant), 4);
        step();
        chk("t1_c8_idle", 32'({busy, grant, done_ok}), 0);
        chk("t1_job_cnt", 32'(job_cnt), 1);

        // Reverse order, requester 1.
        req = 4'b0010; order = 4'b0010;
        step();
        chk("t2_c1_grant", 32'(grant), 2);
        chk("t2_c1_ab", 32'({a, b}), 1);
        req = '0;
        step();
        chk("t2_c2_ab", 32'({a, b}), 0);
        step();
        chk("t2_c3_ab", 32'({a, b}), 0);
        step();
        chk("t2_c4_ab", 32'({a, b}), 2);
        order = '0;
        repeat (3) step();
        chk("t2_c7_done", 32'({done_ok, done_err}), 2);
        step();
        chk("t2_job_cnt", 32'(job_cnt), 2);

        // Timeout: O never rises.
        e_en = 1'b0;
        req = 4'b0001;
        step();
        chk("t3_c1_grant", 32'(grant), 1);
        req = '0;
        repeat (19) step();
        chk("t3_c20_r", 32'({r, busy}), 1);
        step();
        chk("t3_c21_r", 32'(r), 1);
        step();
        chk("t3_c22_done", 32'({done_ok, done_err}), 1);
        step();
        chk("t3_job_cnt", 32'(job_cnt), 3);

        // O on the 16th WAIT_O cycle counts as ok; O during GAP is ignored.
        req = 4'b0001;
        step();
        chk("t3b_c1_grant", 32'(grant), 1);
        req = '0;
        step();
        o_force = 1'b1;
        step();
        o_force = 1'b0;
        repeat (17) step();
        chk("t3b_c20_r", 32'(r), 0);
        o_force = 1'b1;
        step();
        o_force = 1'b0;
        chk("t3b_c21_r", 32'(r), 1);
        step();
        chk("t3b_c22_done", 32'({done_ok, done_err}), 2);
        step();
        chk("t3b_job_cnt", 32'(job_cnt), 4);

        // Round-robin with all requesters held.
        e_en = 1'b1;
        reset = 1'b1;
        step();
        chk("t4_rst_cnt", 32'(job_cnt), 0);
        reset = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(20);
            chk("t4_rr_grant", 32'(grant), 32'(rr_exp[k]));
            if (k == 4) req = '0;
            wait_idle(30);
        end
        chk("t4_job_cnt", 32'(job_cnt), 5);

        // After reset, 1010 grants requester 1 first; then reset mid-job.
        reset = 1'b1;
        step();
        reset = 1'b0;
        req = 4'b1010;
        step();
        chk("t5_first_grant", 32'(grant), 2);
        req = '0;
        step();
        chk("t5_gap_busy", 32'({busy, a, b}), 4);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_abort_outs", 32'({grant, busy, a, b, r, done_ok, done_err}), 0);
        chk("t5_abort_cnt", 32'(job_cnt), 0);
        req = 4'b0001;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        chk("t5_regrant", 32'(grant), 1);
        chk("t5_regrant_a", 32'(a), 1);
        req = '0;
        wait_idle(30);
        chk("t5_job_cnt", 32'(job_cnt), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/abro_job_arbiter.md
# abro_job_arbiter

Round-robin scheduler that shares one ABRO state-machine engine among N requesters. Each granted requester gets one complete ABRO "job":
- the engine's A and B inputs are pulsed in the requested order, separated by a programmable gap;
- the arbiter waits for the engine's O output, with a timeout;
- the engine is pulsed through restart and a pass/fail status is returned.

The block sits between the test/requester logic and the ABRO engine, and owns the engine's A, B and restart inputs.

## Interface
- N, 4: number of requesters (2..8).
- GAP_CYC, 2: idle cycles between first and second input pulse (0..255).
- TIMEOUT, 16: maximum cycles spent in WAIT_O (1..255).
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- req  in  N  per-requester job request; level, sampled only in IDLE.
- order  in  N  per-requester order bit: 0 means A first then B; 1 means B first then A. Latched at grant.
- grant  out  N  one-hot; held from FIRST through DONE inclusive.
- done_ok  out  1  1-cycle pulse in DONE: O was seen.
- done_err  out  1  1-cycle pulse in DONE: timeout.
- busy  out  1  high in every state except IDLE.
- job_cnt  out  8  completed jobs (ok or err); wraps 255→0.
- abro_a  out  1  engine A input.
- abro_b  out  1  engine B input.
- abro_r  out  1  engine synchronous restart.
- abro_o  in  1  engine O output.

## Operation
All outputs are registered. Reset values: all outputs 0; state IDLE; round-robin pointer last = N-1, so requester 0 wins first after reset.

States and transitions:
- **IDLE**: if req != 0, select the first set bit searching from last+1 upward, wrapping modulo N. Latch the winner index and order bit, set grant, go to FIRST. If req == 0, stay.
- **FIRST**: 1 cycle. Drive abro_a (order=0) or abro_b (order=1). Next state is GAP if GAP_CYC > 0, else SECOND.
- **GAP**: exactly GAP_CYC cycles with abro_a = abro_b = 0, counted by an 8-bit counter cleared on entry.
- **SECOND**: 1 cycle, driving the other input. Go to WAIT_O.
- **WAIT_O**: counter cleared on entry, incremented each cycle.
  - abro_o sampled 1 → RESTART; record ok.
  - Else, counter == TIMEOUT-1 → RESTART; record err. WAIT_O therefore lasts at most TIMEOUT cycles.
  - O high on the last allowed cycle counts as ok (O has priority over timeout).
- **RESTART**: 1 cycle, abro_r = 1. Go to DONE.
- **DONE**: 1 cycle.
  - Exactly one of done_ok / done_err = 1.
  - job_cnt increments.
  - last ← winner index.
  - Next state IDLE; grant clears on that transition.

Behavioural rules:
- abro_a, abro_b and abro_r are never high simultaneously, and never high in IDLE or DONE.
- req changes after grant are ignored; the job always runs to DONE.
- A requester still holding req in IDLE competes again normally, and is served only after the other pending requesters.
- Simultaneous requests are resolved purely by round-robin; no requester is starved. Worst-case wait is N-1 jobs.
- abro_o pulses outside WAIT_O are ignored.
- reset asserted mid-job immediately forces all outputs to 0 and the state to IDLE. The aborted job gives no done pulse and job_cnt is unchanged.

## Timing
- Grant latency: req seen at edge k in IDLE → grant and first input pulse visible in the cycle after edge k.
- Job length is 4 + GAP_CYC + W cycles from the first grant cycle to the end of DONE, where W is the WAIT_O cycles, 1..TIMEOUT.
- Back-to-back jobs: DONE → IDLE → FIRST. There is a minimum of 1 IDLE cycle between consecutive grants.
- The engine model is assumed to respond to a pulse on the following edge. The arbiter adds no combinational path from abro_o to any output.

## Test plan
- **Single ok job.** Setup: N=4, GAP_CYC=2, TIMEOUT=16; req=0100 and order[2]=0; the model raises O in the first WAIT_O cycle. Expected:
  - grant=0100; abro_a high in cycle 1, abro_b high in cycle 4, abro_r high in cycle 6;
  - done_ok in cycle 7; job_cnt=1; then IDLE with grant=0.
- **Reverse order.** order[1]=1 → abro_b pulses before abro_a, with 2 zero cycles between them.
- **Timeout.** The model never raises O → WAIT_O lasts exactly 16 cycles, then abro_r, then done_err=1 and done_ok=0.
  - O raised on WAIT_O cycle 16 → done_ok instead.
- **Round-robin.** req=1111 held constant → grant order 0001, 0010, 0100, 1000, 0001, with no repeats until all four have been served.
  - After reset, req=1010 → requester 1 is granted first.
- **GAP_CYC=0.** Second input pulses in the cycle immediately after the first; the total ok job with O returned in the first WAIT_O cycle is 5 cycles.
- **Reset mid-job.** Assert reset during GAP → all outputs 0 immediately; no done pulse; job_cnt unchanged.
  - After release with req=0001, requester 0 is granted (pointer reset).
